// File: rtl/rps_move_capture.sv
// rps_move_capture
//   Player-input front end for the rock-paper-scissors game. Three raw
//   buttons are synchronised, debounced and edge-detected; the first press
//   becomes a move token (ROCK=1, PAPER=2, SCISSORS=3) offered on a
//   valid/ready handshake. After the hand-off, further moves are locked out
//   until every button is released.
//
// Ports
//   CLK         system clock (12 MHz)
//   RST_N       asynchronous active-low reset (released synchronously inside)
//   BTN1..BTN3  raw active-high buttons, asynchronous (ROCK, PAPER, SCISSORS)
//   move_data   encoded move, 0 when nothing is pending
//   move_valid  move_data holds an unconsumed move
//   move_ready  consumer takes the move on an edge where move_valid=1
//   busy        FSM is not in IDLE
//
// Optional feature
//   RPS_MOVE_TIMEOUT_EN: when defined, a move that is not consumed within
//   TIMEOUT_CYCLES cycles is withdrawn and the FSM waits for release.
module rps_move_capture #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = 17
`ifdef RPS_MOVE_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
`endif
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    output logic [1:0] move_data,
    output logic       move_valid,
    input  logic       move_ready,
    output logic       busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] REL_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reset: asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Synchroniser, debouncer and press edge detector, bit i = button i+1.
    logic [2:0] btn_raw;
    logic [2:0] sync_a;
    logic [2:0] sync;
    logic [2:0] deb;
    logic [2:0] deb_q;
    logic [2:0] press;
    logic [2:0][CNT_W-1:0] cnt;

    assign btn_raw = {BTN3, BTN2, BTN1};

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 3'b000;
            sync   <= 3'b000;
            deb_q  <= 3'b000;
        end else begin
            sync_a <= btn_raw;
            sync   <= sync_a;
            deb_q  <= deb;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                deb[gi] <= 1'b0;
                cnt[gi] <= '0;
            end else if (sync[gi] == deb[gi]) begin
                cnt[gi] <= '0;
            end else if (cnt[gi] == CNT_MAX) begin
                deb[gi] <= sync[gi];
                cnt[gi] <= '0;
            end else begin
                cnt[gi] <= cnt[gi] + 1'b1;
            end
        end
    end

    // A button held through reset would look like a fresh press once the
    // cleared debouncer catches up. Presses are only honoured after all
    // synchronised buttons have been low for a full debounce window.
    logic             armed;
    logic [CNT_W-1:0] quiet_cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            quiet_cnt <= '0;
        end else if (!armed) begin
            if (sync != 3'b000)         quiet_cnt <= '0;
            else if (quiet_cnt == CNT_MAX) armed  <= 1'b1;
            else                        quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

    assign press = armed ? (deb & ~deb_q) : 3'b000;

    // Priority SCISSORS > PAPER > ROCK.
    logic [1:0] press_code;
    always_comb begin
        press_code = 2'd0;
        if      (press[2]) press_code = 2'd3;
        else if (press[1]) press_code = 2'd2;
        else if (press[0]) press_code = 2'd1;
    end

    logic [1:0] state;
    logic       hold_timeout;

`ifdef RPS_MOVE_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    // Zero on the first HOLD cycle since it is held clear outside HOLD.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)              tmo_cnt <= '0;
        else if (state != HOLD)  tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign hold_timeout = (state == HOLD) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
`else
    assign hold_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            move_data  <= 2'd0;
            move_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_code != 2'd0) begin
                        move_data  <= press_code;
                        move_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // A transfer and a timeout on the same edge end the same way.
                    if ((move_valid && move_ready) || hold_timeout) begin
                        move_data  <= 2'd0;
                        move_valid <= 1'b0;
                        state      <= REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (deb == 3'b000) state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    move_data  <= 2'd0;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rps_move_capture.sv
// Bench for rps_move_capture with DEBOUNCE_CYCLES=4. Stimulus pushes the
// expected move code into a queue; a monitor on the falling edge pops and
// compares on every valid&ready handshake.
module tb_rps_move_capture;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN1 = 1'b0;
    logic       BTN2 = 1'b0;
    logic       BTN3 = 1'b0;
    logic       move_ready = 1'b0;
    logic [1:0] move_data;
    logic       move_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    logic       prev_valid = 1'b0;
    logic [1:0] prev_data  = 2'd0;

    rps_move_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4)
`ifdef RPS_MOVE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(24'd8)
`endif
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN1(BTN1),
        .BTN2(BTN2),
        .BTN3(BTN3),
        .move_data(move_data),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Inputs change and direct checks happen 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!move_valid && i < 30) begin
            tick(1);
            i++;
        end
        check({name, "_valid_seen"}, int'(move_valid), 1);
    endtask

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_move: got %0d want none", move_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("handshake_data", int'(move_data), int'(mon_exp));
            end
        end
        if (move_valid && prev_valid)
            check("data_stable", int'(move_data), int'(prev_data));
        if (!move_valid)
            check("data_zero_when_idle", int'(move_data), 0);
        prev_valid = move_valid;
        prev_data  = move_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int n;

        // Reset state
        #23;
        check("rst_valid", int'(move_valid), 0);
        check("rst_data", int'(move_data), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        tick(12);

        // T1: BTN2 held, ready=1. With the first sampling edge counted as
        // edge 1, move_valid is seen after edge 7, for one cycle.
        move_ready = 1'b1;
        BTN2 = 1'b1;
        exp_q.push_back(2'd2);
        tick(6);
        check("t1_not_yet", int'(move_valid), 0);
        tick(1);
        check("t1_valid", int'(move_valid), 1);
        check("t1_data", int'(move_data), 2);
        check("t1_busy", int'(busy), 1);
        tick(1);
        check("t1_pulse_end", int'(move_valid), 0);
        BTN2 = 1'b0;
        tick(6);
        check("t1_busy_release_wait", int'(busy), 1);
        tick(1);
        check("t1_busy_clear", int'(busy), 0);

        // T2: 3-cycle glitches with 1-cycle gaps never debounce.
        vcnt = 0;
        for (int r = 0; r < 6; r++) begin
            BTN1 = 1'b1;
            for (int c = 0; c < 3; c++) begin tick(1); vcnt += int'(move_valid); end
            BTN1 = 1'b0;
            tick(1);
            vcnt += int'(move_valid);
        end
        for (int c = 0; c < 10; c++) begin tick(1); vcnt += int'(move_valid); end
        check("t2_no_move", vcnt, 0);
        check("t2_idle", int'(busy), 0);

        // T3: ROCK and SCISSORS together, SCISSORS wins; held 11 valid cycles.
        move_ready = 1'b0;
        BTN1 = 1'b1;
        BTN3 = 1'b1;
        exp_q.push_back(2'd3);
        wait_valid("t3");
        check("t3_data", int'(move_data), 3);
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin vcnt += int'(move_valid); tick(1); end
        check("t3_valid_10", vcnt, 10);
        move_ready = 1'b1;
        check("t3_valid_11th", int'(move_valid), 1);
        tick(1);
        check("t3_done", int'(move_valid), 0);
        move_ready = 1'b0;
        BTN1 = 1'b0;
        BTN3 = 1'b0;
        tick(10);
        check("t3_idle", int'(busy), 0);

        // T4: PAPER pressed and released during HOLD is ignored.
        BTN1 = 1'b1;
        exp_q.push_back(2'd1);
        wait_valid("t4");
        BTN2 = 1'b1;
        tick(8);
        BTN2 = 1'b0;
        tick(8);
        check("t4_still_valid", int'(move_valid), 1);
        check("t4_data", int'(move_data), 1);
        move_ready = 1'b1;
        tick(1);
        check("t4_done", int'(move_valid), 0);
        BTN1 = 1'b0;
        tick(15);
        check("t4_idle", int'(busy), 0);

        // T5: BTN3 held through transfer; BTN1 pressed meanwhile gives nothing.
        BTN3 = 1'b1;
        exp_q.push_back(2'd3);
        wait_valid("t5");
        tick(1);
        check("t5_done", int'(move_valid), 0);
        BTN1 = 1'b1;
        tick(12);
        check("t5_release_wait", int'(busy), 1);
        check("t5_no_move", int'(move_valid), 0);
        BTN1 = 1'b0;
        BTN3 = 1'b0;
        tick(10);
        check("t5_idle", int'(busy), 0);
        BTN1 = 1'b1;
        exp_q.push_back(2'd1);
        wait_valid("t5b");
        check("t5b_data", int'(move_data), 1);
        tick(1);
        BTN1 = 1'b0;
        tick(10);

        // T6: asynchronous reset pulse in HOLD drops the pending move.
        move_ready = 1'b0;
        BTN2 = 1'b1;
        wait_valid("t6");
        check("t6_data", int'(move_data), 2);
        #2 RST_N = 1'b0;
        #1;
        check("t6_rst_valid", int'(move_valid), 0);
        check("t6_rst_data", int'(move_data), 0);
        check("t6_rst_busy", int'(busy), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        move_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 30; c++) begin tick(1); vcnt += int'(move_valid); end
        check("t6_held_no_move", vcnt, 0);
        BTN2 = 1'b0;
        tick(12);
        BTN2 = 1'b1;
        exp_q.push_back(2'd2);
        wait_valid("t6b");
        check("t6b_data", int'(move_data), 2);
        tick(1);
        BTN2 = 1'b0;
        tick(10);
        check("t6_idle", int'(busy), 0);

`ifdef RPS_MOVE_TIMEOUT_EN
        // T7: unconsumed move withdrawn after 8 valid cycles.
        move_ready = 1'b0;
        BTN3 = 1'b1;
        wait_valid("t7");
        n = 0;
        while (move_valid && n < 20) begin
            n++;
            tick(1);
        end
        check("t7_timeout_len", n, 8);
        check("t7_release_wait", int'(busy), 1);
        BTN3 = 1'b0;
        tick(10);
        check("t7_idle", int'(busy), 0);
`else
        n = 0;
`endif

        check("queue_empty", exp_q.size(), n * 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
